// File: rtl/i2c_pkg.sv
// Shared I2C types for the camera-port responder: responder state, address/data widths, R/W codes.
package i2c_pkg;

    typedef logic [6:0]  i2c_addr7_t;
    typedef logic [15:0] i2c_reg_addr_t;
    typedef logic [7:0]  i2c_byte_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_ACK_DEV,
        ST_REG_HI,
        ST_ACK_HI,
        ST_REG_LO,
        ST_ACK_LO,
        ST_WR_DATA,
        ST_ACK_WR,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_slv_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// 2-FF synchronizer followed by a FILTER_LEN-sample glitch filter; level output is registered.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic areset_n,
    input  logic din,
    output logic level
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Idle bus level is high, so everything resets to 1.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_cam_slave.sv
// I2C camera control-port responder (7-bit dev addr, 16-bit reg addr, 8-bit data).
// Define I2C_CAM_SLAVE_RDBACK_EN to add the register file and read transfers.
module i2c_cam_slave
    import i2c_pkg::*;
#(
    parameter i2c_addr7_t SLAVE_ADDR = 7'd16,
    parameter int         REG_AW     = 8,
    parameter int         FILTER_LEN = 3
) (
    input  logic        clk,
    input  logic        areset_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        wr_stb,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);
    logic scl_f, sda_f, scl_q, sda_q;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .areset_n(areset_n), .din(scl_i), .level(scl_f));
    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .areset_n(areset_n), .din(sda_i), .level(sda_f));

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    logic start_det, stop_det, scl_rise, scl_fall;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;

    i2c_slv_state_t state, state_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic [6:0]     shreg, shreg_n;
    i2c_reg_addr_t  ptr, ptr_n;
    i2c_byte_t      tx, tx_n;
    i2c_byte_t      rdata;
    logic           sda_oe_n, busy_n, wr_stb_n;
    i2c_reg_addr_t  wr_addr_n;
    i2c_byte_t      wr_data_n;
    i2c_byte_t      rx_byte;
    logic           byte_done;

    assign rx_byte   = {shreg, sda_f};
    assign byte_done = scl_rise && (bit_cnt == 3'd7);

`ifdef I2C_CAM_SLAVE_RDBACK_EN
    i2c_byte_t mem [0:(2**REG_AW)-1];

    // Written on the same clock that wr_stb is presented.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < 2**REG_AW; i++) mem[i] <= '0;
        end else if (wr_stb_n) begin
            mem[wr_addr_n[REG_AW-1:0]] <= wr_data_n;
        end
    end

    assign rdata = mem[ptr[REG_AW-1:0]];
`else
    assign rdata = '0;
`endif

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            ptr     <= '0;
            tx      <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            ptr     <= ptr_n;
            tx      <= tx_n;
            sda_oe  <= sda_oe_n;
            busy    <= busy_n;
            wr_stb  <= wr_stb_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        ptr_n     = ptr;
        tx_n      = tx;
        sda_oe_n  = sda_oe;
        busy_n    = busy;
        wr_stb_n  = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;

        if (stop_det) begin
            state_n  = ST_IDLE;
            busy_n   = 1'b0;
            sda_oe_n = 1'b0;
        end else if (start_det) begin
            state_n   = ST_DEV_ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else begin
            if (scl_rise && (state inside {ST_DEV_ADDR, ST_REG_HI, ST_REG_LO, ST_WR_DATA})) begin
                shreg_n   = rx_byte[6:0];
                bit_cnt_n = bit_cnt + 3'd1;
            end

            case (state)
                ST_DEV_ADDR: if (byte_done) begin
                    if (rx_byte[7:1] != SLAVE_ADDR)     state_n = ST_IGNORE;
`ifndef I2C_CAM_SLAVE_RDBACK_EN
                    else if (rx_byte[0] == I2C_RW_READ) state_n = ST_IGNORE;
`endif
                    else begin
                        state_n = ST_ACK_DEV;
                        busy_n  = 1'b1;
                    end
                end
                // First SCL fall of an ACK state starts the drive, the second ends the slot.
                // shreg[0] still holds the R/W bit of the device byte here.
                ST_ACK_DEV: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_n = 1'b1;
                    end else if (shreg[0] == I2C_RW_READ) begin
                        state_n   = ST_RD_DATA;
                        bit_cnt_n = '0;
                        tx_n      = rdata;
                        sda_oe_n  = ~rdata[7];
                    end else begin
                        state_n   = ST_REG_HI;
                        bit_cnt_n = '0;
                        sda_oe_n  = 1'b0;
                    end
                end
                ST_REG_HI: if (byte_done) begin
                    ptr_n[15:8] = rx_byte;
                    state_n     = ST_ACK_HI;
                end
                ST_REG_LO: if (byte_done) begin
                    ptr_n[7:0] = rx_byte;
                    state_n    = ST_ACK_LO;
                end
                ST_WR_DATA: if (byte_done) begin
                    wr_stb_n  = 1'b1;
                    wr_addr_n = ptr;
                    wr_data_n = rx_byte;
                    ptr_n     = ptr + 16'd1;
                    state_n   = ST_ACK_WR;
                end
                ST_ACK_HI, ST_ACK_LO, ST_ACK_WR: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_n = 1'b1;
                    end else begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = (state == ST_ACK_HI) ? ST_REG_LO : ST_WR_DATA;
                    end
                end
                // bit_cnt counts rises already sent; the fall after k rises drives bit 7-k.
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        if (bit_cnt == 3'd7) begin
                            ptr_n     = ptr + 16'd1;
                            bit_cnt_n = '0;
                            state_n   = ST_RD_ACK;
                        end else begin
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end else if (scl_fall) begin
                        sda_oe_n = ~tx[~bit_cnt];
                    end
                end
                // bit_cnt==1 marks that the master ACKed on this slot.
                ST_RD_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe_n = 1'b0;
                        end else begin
                            state_n   = ST_RD_DATA;
                            bit_cnt_n = '0;
                            tx_n      = rdata;
                            sda_oe_n  = ~rdata[7];
                        end
                    end else if (scl_rise) begin
                        if (sda_f) state_n   = ST_IGNORE;
                        else       bit_cnt_n = 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cam_slave.sv
// Self-checking bench for i2c_cam_slave: bit-banged I2C master plus a transaction-level register model.
module tb_i2c_cam_slave;
    localparam int Q = 8;   // quarter SCL period in clk cycles

    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic        scl_i = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_i;
    logic        sda_oe, wr_stb, busy;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    assign sda_i = sda_m & ~sda_oe;
    always #5 clk = ~clk;

    i2c_cam_slave dut (
        .clk(clk), .areset_n(areset_n), .scl_i(scl_i), .sda_i(sda_i),
        .sda_oe(sda_oe), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy));

    int total = 0;
    int bad = 0;

    logic [7:0]  mem_m [256];
    logic [15:0] mptr;
    logic [23:0] exp_wr[$];
    logic [23:0] act_wr[$];

    always @(negedge clk) if (areset_n && wr_stb) act_wr.push_back({wr_addr, wr_data});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        mptr = 16'h0000;
        exp_wr.delete();
        act_wr.delete();
    endtask

    task automatic model_wr(input logic [7:0] b);
        mem_m[mptr[7:0]] = b;
        exp_wr.push_back({mptr, b});
        mptr = mptr + 16'd1;
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, "_nwr"}, act_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), act_wr[i], exp_wr[i]);
        act_wr.delete();
        exp_wr.delete();
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_i = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_i = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        scl_i = 1'b0; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_i = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; tick(Q);
            scl_i = 1'b1; tick(2*Q);
            scl_i = 1'b0; tick(Q);
        end
        sda_m = 1'b1; tick(Q);
        scl_i = 1'b1; tick(Q);
        ack = sda_oe;
        tick(Q);
        scl_i = 1'b0; tick(Q);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b, output logic oe_slot);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(Q);
            scl_i = 1'b1; tick(Q);
            b[i] = sda_i;
            tick(Q);
            scl_i = 1'b0; tick(Q);
        end
        sda_m = nack; tick(Q);
        scl_i = 1'b1; tick(Q);
        oe_slot = sda_oe;
        tick(Q);
        scl_i = 1'b0; tick(Q);
        sda_m = 1'b1;
    endtask

    task automatic do_write(input string tag, input logic [7:0] dev, input logic [15:0] addr,
                            input int n, input logic [3:0][7:0] d, input logic exp_ack);
        logic ack, hit;
        hit = (dev[7:1] == 7'd16) && !dev[0];
        bus_start();
        send_byte(dev, ack);
        chk({tag, "_dack"}, ack, exp_ack);
        chk({tag, "_busy"}, busy, exp_ack);
        send_byte(addr[15:8], ack);
        chk({tag, "_hack"}, ack, exp_ack);
        send_byte(addr[7:0], ack);
        chk({tag, "_lack"}, ack, exp_ack);
        if (hit) mptr = addr;
        for (int k = 0; k < n; k++) begin
            send_byte(d[k], ack);
            chk($sformatf("%s_d%0dack", tag, k), ack, exp_ack);
            if (hit) model_wr(d[k]);
        end
        bus_stop();
        chk({tag, "_idle"}, busy, 1'b0);
        chk_writes(tag);
    endtask

`ifdef I2C_CAM_SLAVE_RDBACK_EN
    task automatic do_read(input string tag, input logic [15:0] addr, input int n);
        logic ack, oe_slot;
        logic [7:0] b;
        bus_start();
        send_byte(8'h20, ack);       chk({tag, "_wack"}, ack, 1'b1);
        send_byte(addr[15:8], ack);  chk({tag, "_hack"}, ack, 1'b1);
        send_byte(addr[7:0], ack);   chk({tag, "_lack"}, ack, 1'b1);
        mptr = addr;
        bus_start();
        send_byte(8'h21, ack);       chk({tag, "_rack"}, ack, 1'b1);
        for (int k = 0; k < n; k++) begin
            recv_byte(k == n - 1, b, oe_slot);
            chk($sformatf("%s_rd%0d", tag, k), b, mem_m[mptr[7:0]]);
            chk($sformatf("%s_slot%0d", tag, k), oe_slot, 1'b0);
            mptr = mptr + 16'd1;
        end
        bus_stop();
        chk({tag, "_idle"}, busy, 1'b0);
        chk_writes(tag);
    endtask
`endif

    typedef struct {
        logic [7:0]      dev;
        logic [15:0]     addr;
        int              n;
        logic [3:0][7:0] d;
        logic            exp_ack;
    } wvec_t;

    wvec_t tbl[5];

    initial begin
        logic ack;
        logic [15:0] last_addr;
        logic [7:0] bad_dev[4];
        logic [3:0][7:0] rd;

        tbl[0] = '{dev: 8'h20, addr: 16'h0100, n: 1, d: {8'h00, 8'h00, 8'h00, 8'h01}, exp_ack: 1'b1};
        tbl[1] = '{dev: 8'h20, addr: 16'h00FE, n: 3, d: {8'h00, 8'hCC, 8'hBB, 8'hAA}, exp_ack: 1'b1};
        tbl[2] = '{dev: 8'h22, addr: 16'h0000, n: 2, d: {8'h00, 8'h00, 8'h66, 8'h55}, exp_ack: 1'b0};
        tbl[3] = '{dev: 8'h20, addr: 16'hFFFF, n: 2, d: {8'h00, 8'h00, 8'h22, 8'h11}, exp_ack: 1'b1};
        tbl[4] = '{dev: 8'h30, addr: 16'h1234, n: 1, d: {8'h00, 8'h00, 8'h00, 8'h77}, exp_ack: 1'b0};
        bad_dev[0] = 8'h22; bad_dev[1] = 8'h24; bad_dev[2] = 8'h30; bad_dev[3] = 8'hA0;

        model_reset();
        tick(3);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_wr_stb", wr_stb, 1'b0);
        chk("rst_wr_addr", wr_addr, 16'h0000);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        areset_n = 1'b1;
        tick(2*Q);

        for (int i = 0; i < 5; i++) do_write($sformatf("tbl%0d", i), tbl[i].dev, tbl[i].addr,
                                             tbl[i].n, tbl[i].d, tbl[i].exp_ack);

`ifdef I2C_CAM_SLAVE_RDBACK_EN
        do_read("rs_rd", 16'h0100, 2);
        do_read("wrap_rd", 16'h00FE, 3);
`else
        bus_start();
        send_byte(8'h21, ack);
        chk("noread_ack", ack, 1'b0);
        chk("noread_busy", busy, 1'b0);
        bus_stop();
        chk("noread_oe", sda_oe, 1'b0);
        chk_writes("noread");
`endif

        // 1-clk SDA dip while SCL high must not look like START
        tick(Q);
        sda_m = 1'b0; tick(1);
        sda_m = 1'b1; tick(2*Q);
        chk("glitch_busy", busy, 1'b0);
        scl_i = 1'b0; tick(Q);
        send_byte(8'h20, ack);
        chk("glitch_noack", ack, 1'b0);
        bus_stop();
        chk_writes("glitch");

        // reset while the register-high ACK is being driven
        bus_start();
        send_byte(8'h20, ack);
        chk("rstmid_dack", ack, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b0; tick(Q);
            scl_i = 1'b1; tick(2*Q);
            scl_i = 1'b0; tick(Q);
        end
        sda_m = 1'b1; tick(Q);
        chk("rstmid_drive", sda_oe, 1'b1);
        scl_i = 1'b1; tick(Q);
        areset_n = 1'b0;
        #1;
        chk("rstmid_oe", sda_oe, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        model_reset();
        tick(3);
        areset_n = 1'b1;
        tick(Q);
        scl_i = 1'b0; tick(Q);
        bus_stop();
        rd = {8'h00, 8'h00, 8'h00, 8'h5A};
        do_write("post_rst", 8'h20, 16'h0005, 1, rd, 1'b1);
`ifdef I2C_CAM_SLAVE_RDBACK_EN
        do_read("post_rst_rd", 16'h0004, 3);
`endif

        last_addr = 16'h0000;
        for (int r = 0; r < 10; r++) begin
            int n;
            logic [15:0] a;
            n = $urandom_range(1, 4);
            a = 16'($urandom);
            for (int k = 0; k < 4; k++) rd[k] = 8'($urandom);
            if ($urandom_range(0, 3) == 3) begin
                do_write($sformatf("rnd%0d", r), bad_dev[$urandom_range(0, 3)], a, n, rd, 1'b0);
            end else begin
                do_write($sformatf("rnd%0d", r), 8'h20, a, n, rd, 1'b1);
                last_addr = a;
            end
`ifdef I2C_CAM_SLAVE_RDBACK_EN
            if (r % 2 == 1) do_read($sformatf("rndrd%0d", r), last_addr, $urandom_range(1, 3));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
